// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int DEF_RING_S     = 60;
    localparam int DEF_SNOOZE_S   = 300;
    localparam int DEF_MAX_SNOOZE = 3;

    localparam int SEC_W = 9;

endpackage

// File: rtl/alarm_match_detect.sv
// Minute comparator with a rising-edge register: one trigger per entry into
// the alarm minute, one cycle after the minute starts matching.
module alarm_match_detect
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] alm_min_tens,
    input  logic [3:0] alm_min_ones,
    output logic       trigger
);

    logic min_eq;
    logic min_eq_q;
    logic trigger_q;

    assign min_eq  = ({cur_min_tens, cur_min_ones} == {alm_min_tens, alm_min_ones});
    assign trigger = trigger_q;

    // Remember last match level and register its rising edge as the trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_eq_q  <= 1'b0;
            trigger_q <= 1'b0;
        end else begin
            min_eq_q  <= min_eq;
            trigger_q <= min_eq & ~min_eq_q;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: one FSM sharing a single seconds down-counter between the
// ringing and snooze intervals, with snooze budget and a sticky missed flag.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_S     = DEF_RING_S,
    parameter int SNOOZE_S   = DEF_SNOOZE_S,
    parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] alm_min_tens,
    input  logic [3:0] alm_min_ones,
    input  logic       snooze_req,
    input  logic       stop_req,
    output logic       alarm_led,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state,
    output logic [1:0] snooze_left,
    output logic       missed
);

    localparam logic [SEC_W-1:0] RING_RELOAD   = SEC_W'(RING_S - 1);
    localparam logic [SEC_W-1:0] SNOOZE_RELOAD = SEC_W'(SNOOZE_S - 1);
    localparam logic [1:0]       SNOOZE_BUDGET = 2'(MAX_SNOOZE);

    alarm_state_t     state_q, state_nx;
    logic [SEC_W-1:0] sec_q, sec_nx;
    logic [1:0]       left_q, left_nx;
    logic             blink_q, blink_nx;
    logic             missed_q, missed_nx;
    logic             trigger;

    alarm_match_detect u_match (
        .clk          (clk),
        .rst          (rst),
        .cur_min_tens (cur_min_tens),
        .cur_min_ones (cur_min_ones),
        .alm_min_tens (alm_min_tens),
        .alm_min_ones (alm_min_ones),
        .trigger      (trigger)
    );

    // State, counter, snooze budget, blink phase and missed flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sec_q    <= '0;
            left_q   <= '0;
            blink_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_nx;
            sec_q    <= sec_nx;
            left_q   <= left_nx;
            blink_q  <= blink_nx;
            missed_q <= missed_nx;
        end
    end

    // Next-state logic; priority is disable > stop > snooze > expiry > decrement.
    always_comb begin
        state_nx  = state_q;
        sec_nx    = sec_q;
        left_nx   = left_q;
        blink_nx  = blink_q;
        missed_nx = missed_q;
        if (!alarm_en) begin
            state_nx  = ST_IDLE;
            missed_nx = 1'b0;
        end else begin
            if (stop_req) begin
                missed_nx = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trigger && !set_mode) begin
                        state_nx = ST_RINGING;
                        sec_nx   = RING_RELOAD;
                        left_nx  = SNOOZE_BUDGET;
                        blink_nx = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (stop_req) begin
                        state_nx = ST_ARMED;
                    end else if (snooze_req && left_q != 2'd0) begin
                        state_nx = ST_SNOOZE;
                        sec_nx   = SNOOZE_RELOAD;
                        left_nx  = left_q - 2'd1;
                    end else if (tick_1hz) begin
                        if (sec_q == '0) begin
                            state_nx  = ST_ARMED;
                            missed_nx = 1'b1;
                        end else begin
                            sec_nx   = sec_q - 1'b1;
                            blink_nx = ~blink_q;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_req) begin
                        state_nx = ST_ARMED;
                    end else if (tick_1hz) begin
                        if (sec_q == '0) begin
                            state_nx = ST_RINGING;
                            sec_nx   = RING_RELOAD;
                            blink_nx = 1'b1;
                        end else begin
                            sec_nx = sec_q - 1'b1;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        state       = state_q;
        ringing     = (state_q == ST_RINGING);
        snoozing    = (state_q == ST_SNOOZE);
        alarm_led   = ringing & blink_q;
        snooze_left = left_q;
        missed      = missed_q;
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed testbench for alarm_controller with short ring/snooze intervals.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       alarm_en;
    logic       set_mode;
    logic [2:0] cur_min_tens;
    logic [3:0] cur_min_ones;
    logic [2:0] alm_min_tens;
    logic [3:0] alm_min_ones;
    logic       snooze_req;
    logic       stop_req;
    logic       alarm_led;
    logic       ringing;
    logic       snoozing;
    logic [1:0] state;
    logic [1:0] snooze_left;
    logic       missed;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_controller #(
        .RING_S     (4),
        .SNOOZE_S   (3),
        .MAX_SNOOZE (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .alarm_en     (alarm_en),
        .set_mode     (set_mode),
        .cur_min_tens (cur_min_tens),
        .cur_min_ones (cur_min_ones),
        .alm_min_tens (alm_min_tens),
        .alm_min_ones (alm_min_ones),
        .snooze_req   (snooze_req),
        .stop_req     (stop_req),
        .alarm_led    (alarm_led),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .state        (state),
        .snooze_left  (snooze_left),
        .missed       (missed)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze_req = 1'b1;
        cycle();
        snooze_req = 1'b0;
    endtask

    // Leave minute 07 long enough to clear the edge register, then re-enter it.
    task automatic enter_minute();
        cur_min_ones = 4'd6;
        cycle();
        cycle();
        cur_min_ones = 4'd7;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; set_mode = 1'b0;
        snooze_req = 1'b0; stop_req = 1'b0;
        cur_min_tens = 3'd0; cur_min_ones = 4'd6;
        alm_min_tens = 3'd0; alm_min_ones = 4'd7;
        cycle();
        cycle();
        rst = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if ({alarm_led, ringing, snoozing, missed} !== 4'b0) begin n_bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {alarm_led, ringing, snoozing, missed}); end
        n_cmp++; if (snooze_left !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_snooze_left: got %0d expected 0", snooze_left); end
    endtask

    task automatic test_ring_timeout();
        alarm_en = 1'b1;
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL arm: got %0d expected 1", state); end
        cur_min_ones = 4'd7;
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL trigger_latency: got %0d expected 1", state); end
        cycle();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL ring_entry: got %0d expected 2", state); end
        n_cmp++; if ({alarm_led, ringing} !== 2'b11) begin n_bad++; $display("[TB] FAIL ring_led: got %b expected 11", {alarm_led, ringing}); end
        n_cmp++; if (snooze_left !== 2'd2) begin n_bad++; $display("[TB] FAIL ring_budget: got %0d expected 2", snooze_left); end
        pulse_tick();
        n_cmp++; if (alarm_led !== 1'b0) begin n_bad++; $display("[TB] FAIL blink_1: got %0b expected 0", alarm_led); end
        pulse_tick();
        n_cmp++; if (alarm_led !== 1'b1) begin n_bad++; $display("[TB] FAIL blink_2: got %0b expected 1", alarm_led); end
        pulse_tick();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL ring_hold: got %0d expected 2", state); end
        pulse_tick();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL timeout_state: got %0d expected 1", state); end
        n_cmp++; if ({missed, alarm_led} !== 2'b10) begin n_bad++; $display("[TB] FAIL timeout_missed_led: got %b expected 10", {missed, alarm_led}); end
    endtask

    task automatic test_snooze();
        enter_minute();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL snz_ring: got %0d expected 2", state); end
        pulse_snooze();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("[TB] FAIL snz_enter: got %0d expected 3", state); end
        n_cmp++; if ({snooze_left, snoozing, alarm_led} !== 4'b0110) begin n_bad++; $display("[TB] FAIL snz_flags: got %b expected 0110", {snooze_left, snoozing, alarm_led}); end
        pulse_tick();
        pulse_tick();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("[TB] FAIL snz_hold: got %0d expected 3", state); end
        pulse_tick();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL snz_expire: got %0d expected 2", state); end
        n_cmp++; if ({alarm_led, snooze_left} !== 3'b101) begin n_bad++; $display("[TB] FAIL snz_reentry: got %b expected 101", {alarm_led, snooze_left}); end
        pulse_snooze();
        n_cmp++; if ({state, snooze_left} !== 4'b1100) begin n_bad++; $display("[TB] FAIL snz_second: got %b expected 1100", {state, snooze_left}); end
        for (int i = 0; i < 3; i++) pulse_tick();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL snz_expire2: got %0d expected 2", state); end
        pulse_snooze();
        n_cmp++; if ({state, snooze_left} !== 4'b1000) begin n_bad++; $display("[TB] FAIL snz_exhausted: got %b expected 1000", {state, snooze_left}); end
        n_cmp++; if (missed !== 1'b1) begin n_bad++; $display("[TB] FAIL missed_hold: got %0b expected 1", missed); end
        stop_req = 1'b1;
        cycle();
        stop_req = 1'b0;
        n_cmp++; if ({state, missed} !== 3'b010) begin n_bad++; $display("[TB] FAIL stop_clear: got %b expected 010", {state, missed}); end
    endtask

    task automatic test_stop_and_snooze();
        enter_minute();
        for (int i = 0; i < 4; i++) pulse_tick();
        n_cmp++; if (missed !== 1'b1) begin n_bad++; $display("[TB] FAIL ss_missed_set: got %0b expected 1", missed); end
        enter_minute();
        stop_req = 1'b1;
        snooze_req = 1'b1;
        cycle();
        stop_req = 1'b0;
        snooze_req = 1'b0;
        n_cmp++; if ({state, snooze_left, missed} !== 5'b01100) begin n_bad++; $display("[TB] FAIL stop_over_snooze: got %b expected 01100", {state, snooze_left, missed}); end
    endtask

    task automatic test_set_mode();
        set_mode = 1'b1;
        enter_minute();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL setmode_block: got %0d expected 1", state); end
        set_mode = 1'b0;
        cycle();
        cycle();
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL setmode_no_defer: got %0d expected 1", state); end
    endtask

    task automatic test_disable_in_snooze();
        enter_minute();
        pulse_snooze();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("[TB] FAIL dis_snooze: got %0d expected 3", state); end
        alarm_en = 1'b0;
        cycle();
        n_cmp++; if ({state, alarm_led, snoozing} !== 4'b0000) begin n_bad++; $display("[TB] FAIL dis_idle: got %b expected 0000", {state, alarm_led, snoozing}); end
        alarm_en = 1'b1;
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL rearm: got %0d expected 1", state); end
    endtask

    task automatic test_reset_mid_ring();
        enter_minute();
        for (int i = 0; i < 4; i++) pulse_tick();
        enter_minute();
        n_cmp++; if ({state, missed} !== 3'b101) begin n_bad++; $display("[TB] FAIL rr_ring: got %b expected 101", {state, missed}); end
        rst = 1'b1;
        cycle();
        n_cmp++; if ({state, snooze_left, alarm_led, ringing, snoozing, missed} !== 8'b0) begin n_bad++; $display("[TB] FAIL rr_cleared: got %b expected 00000000", {state, snooze_left, alarm_led, ringing, snoozing, missed}); end
        rst = 1'b0;
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL rr_rearm: got %0d expected 1", state); end
        cycle();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("[TB] FAIL rr_match_at_release: got %0d expected 2", state); end
        stop_req = 1'b1;
        cycle();
        stop_req = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("[TB] FAIL rr_single_trigger: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_set_mode();
        test_disable_in_snooze();
        test_reset_mid_ring();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
